// File: rtl/seg_capture_pkg.sv
// Shared constants for the seven-segment capture block: digit patterns,
// anode slot codes, capture FSM states and an anode-to-slot helper.
package seg_capture_pkg;

  // Active-low segment patterns, bit 6 = g ... bit 0 = a.
  localparam logic [6:0] PAT_0 = 7'b1000000;
  localparam logic [6:0] PAT_1 = 7'b1111001;
  localparam logic [6:0] PAT_2 = 7'b0100100;
  localparam logic [6:0] PAT_3 = 7'b0110000;
  localparam logic [6:0] PAT_4 = 7'b0011001;
  localparam logic [6:0] PAT_5 = 7'b0010010;
  localparam logic [6:0] PAT_6 = 7'b0000010;
  localparam logic [6:0] PAT_7 = 7'b1111000;
  localparam logic [6:0] PAT_8 = 7'b0000000;
  localparam logic [6:0] PAT_9 = 7'b0010000;

  localparam logic [3:0] AN_HUNDREDS = 4'b0111;
  localparam logic [3:0] AN_TENS     = 4'b1011;
  localparam logic [3:0] AN_ONES     = 4'b1101;
  localparam logic [3:0] AN_BLANK    = 4'b1111;

  typedef enum logic [1:0] {
    WAIT_H,
    WAIT_T,
    WAIT_O
  } state_t;

  typedef enum logic [1:0] {
    SLOT_NONE,
    SLOT_H,
    SLOT_T,
    SLOT_O
  } slot_t;

  function automatic slot_t slot_of(input logic [3:0] an);
    case (an)
      AN_HUNDREDS: return SLOT_H;
      AN_TENS:     return SLOT_T;
      AN_ONES:     return SLOT_O;
      default:     return SLOT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational decode of an active-low seven-segment pattern to a BCD digit;
// anything that is not a clean 0-9 glyph is flagged invalid.
module seg_pattern_decode
  import seg_capture_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       invalid
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    digit   = 4'd0;
    invalid = 1'b0;
    case (seg)
      PAT_0:   digit = 4'd0;
      PAT_1:   digit = 4'd1;
      PAT_2:   digit = 4'd2;
      PAT_3:   digit = 4'd3;
      PAT_4:   digit = 4'd4;
      PAT_5:   digit = 4'd5;
      PAT_6:   digit = 4'd6;
      PAT_7:   digit = 4'd7;
      PAT_8:   digit = 4'd8;
      PAT_9:   digit = 4'd9;
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_segment_capture.sv
// Recovers a 0-255 value from a scanned 3-digit display (hundreds/tens/ones).
// Optional partial-frame timeout is built only when SEG_CAPTURE_TIMEOUT_EN is defined.
module seven_segment_capture
  import seg_capture_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic       CLOCK,
  input  logic       RESETN,
  input  logic [3:0] an,
  input  logic [6:0] seg,
  output logic [7:0] number,
  output logic       number_valid,
  input  logic       number_ready,
  output logic       decode_err,
  output logic       range_err,
  output logic       overrun
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  logic [3:0] an_meta, an_sync, an_last;
  logic [6:0] seg_meta, seg_sync, seg_last;
  logic [7:0] stab_cnt, stab_next;
  slot_t      slot;
  logic       accept;

  logic [3:0] digit;
  logic       invalid;
  logic [3:0] hund_q, tens_q;
  logic [9:0] frame_sum;
  state_t     state;
  logic       timeout_hit;

  // Synchronizers idle at all ones, which reads as a blanked display.
  always_ff @(posedge CLOCK) begin
    if (!RESETN) begin
      an_meta  <= '1;
      an_sync  <= '1;
      seg_meta <= '1;
      seg_sync <= '1;
    end else begin
      // NOTE: non-blocking so both flop stages sample the pre-edge values.
      an_meta  <= an;
      an_sync  <= an_meta;
      seg_meta <= seg;
      seg_sync <= seg_meta;
    end
  end

  // stab_cnt holds how many consecutive samples the current pair has matched,
  // saturating at STABLE_CYCLES so a held pair is accepted exactly once.
  always_comb begin
    slot = slot_of(an_sync);
    if (slot == SLOT_NONE)
      stab_next = 8'd0;
    else if (an_sync != an_last || seg_sync != seg_last)
      stab_next = 8'd1;
    else if (stab_cnt == STABLE_MAX)
      stab_next = stab_cnt;
    else
      stab_next = stab_cnt + 8'd1;
    accept = (stab_next == STABLE_MAX) && (stab_cnt != STABLE_MAX);
  end

  always_ff @(posedge CLOCK) begin
    if (!RESETN) begin
      an_last  <= '1;
      seg_last <= '1;
      stab_cnt <= 8'd0;
    end else begin
      an_last  <= an_sync;
      seg_last <= seg_sync;
      stab_cnt <= stab_next;
    end
  end

  seg_pattern_decode u_decode (
    .seg     (seg_sync),
    .digit   (digit),
    .invalid (invalid)
  );

  assign frame_sum = 10'(hund_q) * 10'd100 + 10'(tens_q) * 10'd10 + 10'(digit);

`ifdef SEG_CAPTURE_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  assign timeout_hit = (state != WAIT_H) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLOCK) begin
    if (!RESETN)
      to_cnt <= '0;
    else if (accept || state == WAIT_H || timeout_hit)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 1'b1;
  end
`else
  // Never true for a legal TIMEOUT_CYCLES; partial frames wait forever.
  assign timeout_hit = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge CLOCK) begin
    if (!RESETN) begin
      // NOTE: every register reloads on reset, so a reset mid-frame drops latched digits.
      state        <= WAIT_H;
      hund_q       <= 4'd0;
      tens_q       <= 4'd0;
      number       <= 8'd0;
      number_valid <= 1'b0;
      decode_err   <= 1'b0;
      range_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      decode_err <= 1'b0;
      range_err  <= 1'b0;
      if (number_valid && number_ready)
        number_valid <= 1'b0;

      if (accept) begin
        if (invalid) begin
          decode_err <= 1'b1;
          state      <= WAIT_H;
        end else begin
          case (slot)
            SLOT_H: begin
              hund_q <= digit;
              state  <= WAIT_T;
            end
            SLOT_T: begin
              if (state == WAIT_T) begin
                tens_q <= digit;
                state  <= WAIT_O;
              end else begin
                state <= WAIT_H;
              end
            end
            SLOT_O: begin
              state <= WAIT_H;
              if (state == WAIT_O) begin
                if (frame_sum > 10'd255)
                  range_err <= 1'b1;
                else if (number_valid && !number_ready)
                  overrun <= 1'b1;
                else begin
                  // A load during a handshake keeps valid high for the new frame.
                  number       <= frame_sum[7:0];
                  number_valid <= 1'b1;
                end
              end
            end
            default: state <= state;
          endcase
        end
      end else if (timeout_hit) begin
        state  <= WAIT_H;
        hund_q <= 4'd0;
        tens_q <= 4'd0;
      end
    end
  end

endmodule

// File: doc/seven_segment_capture.md
SEVEN_SEGMENT_CAPTURE -- requirements
Module: seven_segment_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 16: consecutive identical samples required to accept a digit (range 2..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 1048576: idle cycles before a partial frame is discarded.
REQ-003 CLOCK  input  1  system clock; all logic on rising edge.
REQ-004 RESETN  input  1  reset, synchronous and active-low.
REQ-005 an  input  4  active-low anode lines from a multiplexed display driver.
REQ-006 seg  input  7  active-low segment lines, bit 0 = segment a.
REQ-007 number  output  8  reconstructed value, hundreds*100 + tens*10 + ones.
REQ-008 number_valid  output  1  number holds an unconsumed frame.
REQ-009 number_ready  input  1  consumer accepts number when number_valid is high.
REQ-010 decode_err  output  1  one-cycle pulse: accepted digit pattern is not 0-9.
REQ-011 range_err  output  1  one-cycle pulse: completed frame value exceeds 255.
REQ-012 overrun  output  1  sticky: a completed frame was dropped because number_valid was still pending.

Function
REQ-013 an and seg shall pass through a 2-flop synchronizer; all further logic shall use the synchronized copy.
REQ-014 Digit slots: an=0111 hundreds, 1011 tens, 1101 ones; any other an value, including 1111 blanking, shall be treated as blank, resetting the stability counter without changing FSM state.
REQ-015 A (an,seg) pair shall be accepted in the cycle it has been identical for STABLE_CYCLES consecutive synchronized samples; it shall be accepted once only, until the pair changes.
REQ-016 Accepted seg shall decode 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9; any other pattern pulses decode_err and returns the FSM to WAIT_H.
REQ-017 FSM states WAIT_H, WAIT_T, WAIT_O; accepted hundreds in any state -> latch, go WAIT_T; tens in WAIT_T -> latch, go WAIT_O; ones in WAIT_O -> latch, complete frame, go WAIT_H; any other accepted digit -> WAIT_H without latching.
REQ-018 Frame sum shall be computed 10 bits wide (max 999); if the sum is >255, pulse range_err and emit nothing.
REQ-019 number and number_valid shall update the cycle after the ones digit is accepted (1-cycle latency).
REQ-020 number_valid shall fall in the cycle after number_valid && number_ready; number shall be stable while number_valid is high.
REQ-021 A frame completing while number_valid && !number_ready shall be dropped, setting overrun; a frame completing in the same cycle as a handshake shall be loaded, number_valid staying high.

Reset
REQ-022 With RESETN low at a rising edge: number=0, number_valid=0, decode_err=0, range_err=0, overrun=0, FSM=WAIT_H, synchronizer flops=all ones, counters=0.
REQ-023 Reset mid-frame shall discard latched digits; the first frame after reset shall need a full hundreds-tens-ones sequence.

Configuration
REQ-024 With SEG_CAPTURE_TIMEOUT_EN defined: a counter shall clear on every accepted digit, and reaching TIMEOUT_CYCLES outside WAIT_H shall force WAIT_H, discarding partial digits.
REQ-025 Without SEG_CAPTURE_TIMEOUT_EN: no timeout counter shall be built; partial frames persist indefinitely.

Structure
REQ-026 A shared package seg_capture_pkg shall hold the 7-bit digit pattern constants, the anode slot constants and the FSM state enum.
REQ-027 Pattern decode shall be a sub-module seg_pattern_decode (seg in; digit[3:0] and invalid out; purely combinational).

Verification
REQ-028 Scan 2,5,5 (STABLE_CYCLES=16, 100 cycles per digit, blanking between) -> number=255, one number_valid; after ready, valid=0.
REQ-029 Scan 3,0,0 -> range_err pulses once; number_valid stays 0.
REQ-030 seg=1111111 held on tens slot -> decode_err pulses once; a following 1,2,3 scan gives number=123.
REQ-031 Two frames 0,4,2 then 0,0,7 with number_ready=0 -> number=42, overrun=1; ready pulse -> valid drops.
REQ-032 Glitch: tens pattern held 10 cycles, then a steady 6 -> only 6 latched; 1,6,0 gives number=160.
REQ-033 With SEG_CAPTURE_TIMEOUT_EN and TIMEOUT_CYCLES=1000: hundreds=1, 1200-cycle blank, then tens 2, ones 3 -> no frame; full scan 1,2,3 -> 123.
